dt_binarize_pack: RTL and testbench

- Inverse-direction companion to the distance-transform engine.
- Reads the 128x128 8-bit distance map from the result RAM, one pixel per cycle, and thresholds each value to one bit.
- Packs 16 bits per word, MSB first, and writes 1024 16-bit words into an image RAM in the same layout as the binary source ROM.
- Also reports the count of set pixels. Used for erosion-by-distance and for round-trip checks of the transform.

---
 rtl/dt_pkg.sv | 31 +++
 rtl/dt_binarize_pack_if.sv | 34 +++
 rtl/dt_bit_packer.sv | 47 ++++
 rtl/dt_binarize_pack.sv | 147 ++++++++++++++
 tb/tb_dt_binarize_pack.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dt_pkg.sv
// Shared constants, FSM encoding and pixel-to-word mapping for the distance-transform blocks.
package dt_pkg;

    localparam int unsigned IMG_W       = 128;
    localparam int unsigned PIX_W       = 8;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned ADDR_PIX_W  = 14;
    localparam int unsigned ADDR_WORD_W = 10;
    localparam int unsigned BIT_IDX_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StFlush,
        StFinish
    } dt_state_e;

    typedef struct packed {
        logic [ADDR_WORD_W-1:0] word;
        logic [BIT_IDX_W-1:0]   bit_pos;
    } pix_loc_t;

    // Column 0 of each 16-pixel group lands in the word MSB.
    function automatic pix_loc_t pix_to_word(input logic [ADDR_PIX_W-1:0] k);
        pix_loc_t loc;
        loc.word    = k[ADDR_PIX_W-1:BIT_IDX_W];
        loc.bit_pos = 4'hF - k[BIT_IDX_W-1:0];
        return loc;
    endfunction

endpackage

// File: rtl/dt_binarize_pack_if.sv
// Result-RAM read port and image-RAM write port seen by the binarize/pack engine.
interface dt_binarize_pack_if #(
    parameter int unsigned PIX_W       = dt_pkg::PIX_W,
    parameter int unsigned WORD_W      = dt_pkg::WORD_W,
    parameter int unsigned ADDR_PIX_W  = dt_pkg::ADDR_PIX_W,
    parameter int unsigned ADDR_WORD_W = dt_pkg::ADDR_WORD_W
);

    logic                   res_rd;
    logic [ADDR_PIX_W-1:0]  res_addr;
    logic [PIX_W-1:0]       res_di;
    logic                   img_wr;
    logic [ADDR_WORD_W-1:0] img_addr;
    logic [WORD_W-1:0]      img_do;

    modport master (
        output res_rd,
        output res_addr,
        input  res_di,
        output img_wr,
        output img_addr,
        output img_do
    );

    modport slave (
        input  res_rd,
        input  res_addr,
        output res_di,
        input  img_wr,
        input  img_addr,
        input  img_do
    );

endinterface

// File: rtl/dt_bit_packer.sv
// Serial-in, MSB-first bit packer: flags the cycle in which the incoming bit completes a word.
module dt_bit_packer #(
    parameter int unsigned WORD_W = dt_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              bit_valid_i,
    input  logic              bit_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    // Only the WORD_W-1 earlier bits are stored; the final bit is merged combinationally.
    logic [WORD_W-2:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (bit_valid_i) begin
            sreg_d = {sreg_q[WORD_W-3:0], bit_i};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_comb begin
        word_valid_o = bit_valid_i && !clear_i && (cnt_q == CNT_W'(WORD_W - 1));
        word_o       = {sreg_q, bit_i};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dt_binarize_pack.sv
// Thresholds the distance map one pixel per cycle, packs 16 bits per image word and counts set pixels.
module dt_binarize_pack
    import dt_pkg::*;
#(
    parameter int unsigned IMG_W  = dt_pkg::IMG_W,
    parameter int unsigned PIX_W  = dt_pkg::PIX_W,
    parameter int unsigned WORD_W = dt_pkg::WORD_W,
    localparam int unsigned ADDR_PIX_W  = 2 * $clog2(IMG_W),
    localparam int unsigned ADDR_WORD_W = ADDR_PIX_W - $clog2(WORD_W),
    localparam int unsigned CNT_W       = ADDR_PIX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PIX_W-1:0]  thr,
    dt_binarize_pack_if.master ram,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  set_cnt
);

    dt_state_e              state_q, state_d;
    logic [PIX_W-1:0]       thr_q, thr_d;
    logic                   res_rd_q, res_rd_d;
    logic [ADDR_PIX_W-1:0]  res_addr_q, res_addr_d;
    logic                   img_wr_q, img_wr_d;
    logic [ADDR_WORD_W-1:0] img_addr_q, img_addr_d;
    logic [WORD_W-1:0]      img_do_q, img_do_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       set_cnt_q, set_cnt_d;

    logic [PIX_W-1:0]  thr_eff;
    logic              pix_bit;
    logic              accept;
    logic              sample;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    // A zero threshold would make every pixel set; treat it as "any nonzero distance".
    always_comb begin
        thr_eff = (thr_q == '0) ? PIX_W'(1) : thr_q;
        pix_bit = (ram.res_di >= thr_eff);
        accept  = (state_q == StIdle) && start;
        sample  = (state_q == StRead);
    end

    dt_bit_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (accept),
        .bit_valid_i  (sample),
        .bit_i        (pix_bit),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        res_rd_d   = res_rd_q;
        res_addr_d = res_addr_q;
        img_wr_d   = 1'b0;
        img_addr_d = img_addr_q;
        img_do_d   = img_do_q;
        busy_d     = busy_q;
        done_d     = done_q;
        set_cnt_d  = set_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    thr_d      = thr;
                    set_cnt_d  = '0;
                    res_addr_d = '0;
                    res_rd_d   = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = StRead;
                end
            end
            StRead: begin
                set_cnt_d  = set_cnt_q + CNT_W'(pix_bit);
                res_addr_d = res_addr_q + 1'b1;
                if (word_valid) begin
                    img_wr_d   = 1'b1;
                    img_addr_d = res_addr_q[ADDR_PIX_W-1 -: ADDR_WORD_W];
                    img_do_d   = word;
                end
                if (res_addr_q == '1) begin
                    res_rd_d = 1'b0;
                    state_d  = StFlush;
                end
            end
            // The last word's write strobe is on the bus during this state.
            StFlush: begin
                state_d = StFinish;
            end
            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            thr_q      <= '0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            img_wr_q   <= 1'b0;
            img_addr_q <= '0;
            img_do_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            set_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            img_wr_q   <= img_wr_d;
            img_addr_q <= img_addr_d;
            img_do_q   <= img_do_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            set_cnt_q  <= set_cnt_d;
        end
    end

    assign ram.res_rd   = res_rd_q;
    assign ram.res_addr = res_addr_q;
    assign ram.img_wr   = img_wr_q;
    assign ram.img_addr = img_addr_q;
    assign ram.img_do   = img_do_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign set_cnt      = set_cnt_q;

endmodule

// File: tb/tb_dt_binarize_pack.sv
// Directed bench for dt_binarize_pack: synthetic distance maps, captured image words and pass timing.
module tb_dt_binarize_pack;

    typedef struct {
        string       name;
        int          mode;
        logic [7:0]  thr;
        logic [15:0] w0;
        logic [15:0] w16;
        logic [15:0] wlo;
        logic [15:0] whi;
        int          cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thr;
    logic        busy;
    logic        done;
    logic [14:0] set_cnt;

    int mode      = 0;
    int cyc       = 0;
    int total     = 0;
    int bad       = 0;
    int wr_cnt    = 0;
    int wr_base   = 0;
    int order_err = 0;
    int err_base  = 0;
    int w0_cyc    = -1;
    int pass_p    = 0;
    int wc        = 0;

    logic [15:0] img_mem [1024];
    vec_t        vecs [4];
    vec_t        rv;

    // Map modes: 0 all zero, 1 value 1 at pixels 0 and 15, 2 ramp k[7:0], 3 all 255.
    function automatic logic [7:0] map_val(input int m, input logic [13:0] k);
        case (m)
            1:       return (k == 14'd0 || k == 14'd15) ? 8'd1 : 8'd0;
            2:       return k[7:0];
            3:       return 8'hFF;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input vec_t v, input int n);
        if (n == 0) return v.w0;
        if (n % 16 == 0) return v.w16;
        return ((n & 8) != 0) ? v.whi : v.wlo;
    endfunction

    dt_binarize_pack_if bus ();

    dt_binarize_pack dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .thr     (thr),
        .ram     (bus),
        .busy    (busy),
        .done    (done),
        .set_cnt (set_cnt)
    );

    assign bus.res_di = map_val(mode, bus.res_addr);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.img_wr === 1'b1) begin
            if (int'(bus.img_addr) != wr_cnt - wr_base) order_err++;
            if (bus.img_addr == 10'd0) w0_cyc = cyc;
            img_mem[bus.img_addr] = bus.img_do;
            wr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".res_rd"},   32'(bus.res_rd),   0);
        check({tag, ".res_addr"}, 32'(bus.res_addr), 0);
        check({tag, ".img_wr"},   32'(bus.img_wr),   0);
        check({tag, ".img_addr"}, 32'(bus.img_addr), 0);
        check({tag, ".img_do"},   32'(bus.img_do),   0);
        check({tag, ".busy"},     32'(busy),         0);
        check({tag, ".done"},     32'(done),         0);
        check({tag, ".set_cnt"},  32'(set_cnt),      0);
    endtask

    task automatic do_start(input int m, input logic [7:0] t);
        @(negedge clk);
        mode     = m;
        thr      = t;
        wr_base  = wr_cnt;
        err_base = order_err;
        start    = 1'b1;
        pass_p   = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("start.busy",     32'(busy),         1);
        check("start.done_clr", 32'(done),         0);
        check("start.res_rd",   32'(bus.res_rd),   1);
        check("start.res_addr", 32'(bus.res_addr), 0);
    endtask

    task automatic finish_pass(input vec_t v);
        int dcyc = -1;
        int fi   = -1;
        for (int i = 0; i < 17000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        check({v.name, ".done_lat"}, 32'(dcyc - pass_p),      32'd16386);
        check({v.name, ".writes"},   32'(wr_cnt - wr_base),   32'd1024);
        check({v.name, ".order"},    32'(order_err - err_base), 0);
        check({v.name, ".w0_lat"},   32'(w0_cyc - pass_p),    32'd16);
        check({v.name, ".busy"},     32'(busy),               0);
        check({v.name, ".set_cnt"},  32'(set_cnt),            32'(v.cnt));
        for (int n = 0; n < 1024; n++) begin
            if (fi < 0 && img_mem[n] !== exp_word(v, n)) fi = n;
        end
        if (fi < 0) fi = 0;
        check($sformatf("%s.word[%0d]", v.name, fi), 32'(img_mem[fi]), 32'(exp_word(v, fi)));
    endtask

    initial begin
        vecs[0] = '{"zero_thr0",   0, 8'd0,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0};
        vecs[1] = '{"two_px_thr0", 1, 8'd0,   16'h8001, 16'h0000, 16'h0000, 16'h0000, 2};
        vecs[2] = '{"ramp_thr128", 2, 8'd128, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 8192};
        vecs[3] = '{"ff_thr255",   3, 8'd255, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16384};
        rv      = '{"ramp_thr3",   2, 8'd3,   16'h1FFF, 16'h1FFF, 16'hFFFF, 16'hFFFF, 16192};

        reset = 1'b0;
        start = 1'b0;
        thr   = 8'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_start(vecs[i].mode, vecs[i].thr);
            finish_pass(vecs[i]);
        end

        // Abort mid-pass, with a start presented in the same cycle as reset.
        do_start(3, 8'd255);
        while (cyc < pass_p + 4999) @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_idle("abort");
        reset = 1'b1;
        start = 1'b0;
        wc    = wr_cnt;
        check("abort.writes", 32'(wc - wr_base), 32'd312);
        repeat (200) @(negedge clk);
        check("abort.no_wr", 32'(wr_cnt - wc), 0);
        check("abort.busy",  32'(busy),        0);

        // Restart; a second start with a new threshold mid-pass must be ignored.
        do_start(rv.mode, rv.thr);
        while (cyc < pass_p + 99) @(negedge clk);
        start = 1'b1;
        thr   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        finish_pass(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
